// File: rtl/pc_fetch_sequencer.sv
// Fetch PC sequencer: holds the IF fetch address, steps it by 4 and applies ID-stage redirects.
// Latency: a redirect updates pc on the next edge; a redirect made during a stall is buffered and applied once the stall clears.
// Backpressure: never pushes back on redirect_valid; one-entry pending buffer, newest redirect wins; stall holds the PC.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus_4,
    output logic             fetch_valid,
    output logic             flush_if,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_pend_addr;
    logic               r_pend_mis;
    logic               r_misalign;
    logic [CNT_W-1:0]   r_cnt;

    logic [31:0]        w_eff_addr;
    logic               w_rd_mis;
    logic               w_apply;
    logic               w_capture;
    logic [31:0]        w_apply_addr;
    logic               w_apply_mis;

    // Misaligned targets are forced to a word boundary and only reported.
    assign w_eff_addr = {redirect_addr[31:2], 2'b00};
    assign w_rd_mis   = (redirect_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = RUN;
            RUN:     if (stall && redirect_valid) w_next_state = PEND;
            PEND:    if (!stall) w_next_state = RUN;
            default: w_next_state = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid  = 1'b0;
        flush_if     = 1'b0;
        w_apply      = 1'b0;
        w_capture    = 1'b0;
        w_apply_addr = w_eff_addr;
        w_apply_mis  = w_rd_mis;
        case (r_state)
            RUN: begin
                fetch_valid = !stall;
                flush_if    = !stall && redirect_valid;
                w_apply     = !stall && redirect_valid;
                w_capture   = stall && redirect_valid;
            end
            PEND: begin
                flush_if  = !stall;
                w_apply   = !stall;
                w_capture = stall && redirect_valid;
                // A redirect arriving on the release cycle supersedes the buffered one.
                if (!redirect_valid) begin
                    w_apply_addr = r_pend_addr;
                    w_apply_mis  = r_pend_mis;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_pend_addr <= 32'h0;
            r_pend_mis  <= 1'b0;
            r_misalign  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_apply) begin
                r_pc <= w_apply_addr;
            end else if (fetch_valid && imem_ready) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_capture) begin
                r_pend_addr <= w_eff_addr;
                r_pend_mis  <= w_rd_mis;
            end
            r_misalign <= w_apply && w_apply_mis;
            if (w_apply && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign pc           = r_pc;
    assign pc_plus_4    = r_pc + 32'd4;
    assign misalign     = r_misalign;
    assign redirect_cnt = r_cnt;

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-side PC sequencer for the five-stage MIPS pipeline. It holds the architectural fetch PC and advances it by 4 each fetch. It takes redirects from the ID-stage jump/branch target path (`redirect_addr`, qualified by `redirect_valid`) and flushes the wrong-path instruction. A redirect that arrives while IF is stalled is buffered and applied later. The block sits between the ID-stage target logic and the instruction memory port.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `CNT_W`, default 16: width of the redirect event counter.

Ports (clock and reset first):
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `stall` in 1: hazard-unit hold for IF. Blocks all PC updates.
- `imem_ready` in 1: instruction memory accepted or returned the fetch at `pc` this cycle.
- `redirect_valid` in 1: ID resolved a taken j/jal/jr/branch this cycle.
- `redirect_addr` in 32: target from ID. Sampled only when `redirect_valid` = 1.
- `pc` out 32: current fetch address (registered).
- `pc_plus_4` out 32: `pc` + 4, combinational, forwarded to IF/ID.
- `fetch_valid` out 1: `pc` is a valid fetch request this cycle.
- `flush_if` out 1: kill the instruction being written into IF/ID this cycle.
- `misalign` out 1: one-cycle registered pulse. An applied redirect target had nonzero bits [1:0].
- `redirect_cnt` out `CNT_W`: count of applied redirects, saturating.

## Operation
- FSM states: `BOOT`, `RUN`, `PEND`.
  - `BOOT` is entered by reset and left unconditionally on the first clock edge, going to `RUN`.
- `eff_addr` = `redirect_addr` with bits [1:0] forced to 2'b00. The misalignment is reported but not trapped.

Update rules, evaluated in `RUN`, in priority order:
1. `stall` = 1 and `redirect_valid` = 1:
   - `pend_addr` <= `eff_addr`; `pend_mis` <= (`redirect_addr`[1:0] != 0).
   - Go to `PEND`. `pc` holds.
2. `stall` = 1: hold everything.
3. `redirect_valid` = 1:
   - `pc` <= `eff_addr`.
   - `flush_if` = 1 this cycle.
   - `misalign` is set next cycle if the target was misaligned.
   - `redirect_cnt` increments. This happens regardless of `imem_ready`; the fetch in flight is abandoned.
4. `imem_ready` = 1: `pc` <= `pc` + 4.
5. Otherwise: hold.

Rules in `PEND`:
- `stall` = 1 and `redirect_valid` = 1: overwrite `pend_addr`/`pend_mis` (latest redirect wins). No extra count.
- `stall` = 0:
  - `pc` <= `pend_addr`, or `eff_addr` if `redirect_valid` = 1 that same cycle (the newer redirect wins).
  - `flush_if` = 1; `misalign` follows the chosen target; `redirect_cnt` increments once.
  - Go to `RUN`.

Outputs:
- `fetch_valid` = (state == `RUN`) && !`stall`. It is 0 in `BOOT` and in `PEND`, so no wrong-path fetch is issued.
- `flush_if` = combinational.
  - In `RUN`: !`stall` && `redirect_valid`.
  - In `PEND`: !`stall`.
  - Otherwise 0.

Arithmetic:
- `pc` + 4 wraps modulo 2^32: 32'hFFFF_FFFC goes to 32'h0000_0000.
- `redirect_cnt` saturates at all-ones.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - `pc` = `RESET_PC`, `pc_plus_4` = `RESET_PC` + 4.
  - `fetch_valid` = 0, `flush_if` = 0, `misalign` = 0, `redirect_cnt` = 0.
  - State `BOOT`, `pend_addr` = 0.
- First edge after `rst_n` rises: state becomes `RUN`, so `fetch_valid` = 1 (if no stall) with `pc` = `RESET_PC`.
- Redirect latency:
  - `redirect_valid` in cycle N with no stall gives `pc` = target in N+1.
  - `flush_if` is high in cycle N.
  - `misalign` is high in N+1 only.
- Stalled redirect: captured in N. It is applied on the first edge where `stall` = 0, with `flush_if` high in that cycle.
- `redirect_valid` is a single-cycle strobe. The block never backpressures it; buffering depth is 1, newest wins.
- Reset asserted mid-`PEND` discards the pending target.

## Test plan
- Reset release, `stall` = 0, `imem_ready` = 1: `pc` sequence 0x3000, 0x3004, 0x3008. `fetch_valid` is 0 in the first cycle, then 1.
- `redirect_valid` with target 0x0040_0010 at `pc` 0x3008: `flush_if` = 1 that cycle. Next `pc` = 0x0040_0010, `redirect_cnt` = 1.
- `stall` = 1, redirect to 0x5000, then a redirect to 0x6000 two cycles later, `stall` released after 4 cycles:
  - `fetch_valid` = 0 while in `PEND`.
  - `pc` = 0x6000 after release.
  - `flush_if` is a single pulse; `redirect_cnt` +1.
- Redirect to 0x1003: `pc` = 0x1000, and `misalign` pulses for 1 cycle.
- `imem_ready` = 0 for 3 cycles: `pc` holds. A redirect arriving during the wait is applied next cycle.
- `pc` at 0xFFFF_FFFC with `imem_ready`: `pc` becomes 0x0. With `CNT_W` = 2 and 5 redirects, `redirect_cnt` stays at 3.
